// File: rtl/fifo_wr_ctrl.sv
//------------------------------------------------------------------------------
// fifo_wr_ctrl : write-side pointer/flag controller of an async FIFO (w_clk domain)
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_inc,
  input  logic [ADDR_W:0]   wq2_rptr,
  input  logic              w_ovf_clr,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_ptr,
  output logic              w_full,
  output logic              w_almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              w_overflow
);

  localparam logic [ADDR_W:0] c_af_thresh = AF_THRESH[ADDR_W:0];

  logic [ADDR_W:0] w_bin_q, w_bin_d;
  logic [ADDR_W:0] w_gray_q, w_gray_d;
  logic [ADDR_W:0] w_level_q, w_level_d;
  logic [ADDR_W:0] rbin;
  logic            w_full_q, w_full_d;
  logic            w_af_q, w_af_d;
  logic            w_ovf_q, w_ovf_d;

  always_comb begin
    w_en     = w_inc && !w_full_q;
    w_bin_d  = w_bin_q + {{ADDR_W{1'b0}}, w_en};
    w_gray_d = w_bin_d ^ (w_bin_d >> 1);

    // Gray-to-binary of the synchronised read pointer, MSB downwards
    rbin         = '0;
    rbin[ADDR_W] = wq2_rptr[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end

    w_level_d = w_bin_d - rbin;
    w_full_d  = (w_gray_d == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
    w_af_d    = (w_level_d >= c_af_thresh);

    // A blocked write in the same cycle as a clear keeps the flag set
    w_ovf_d = w_ovf_q;
    if (w_ovf_clr) begin
      w_ovf_d = 1'b0;
    end
    if (w_inc && w_full_q) begin
      w_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_bin_q   <= '0;
      w_gray_q  <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_af_q    <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      w_gray_q  <= w_gray_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_af_q    <= w_af_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign w_addr        = w_bin_q[ADDR_W-1:0];
  assign w_ptr         = w_gray_q;
  assign w_full        = w_full_q;
  assign w_almost_full = w_af_q;
  assign w_level       = w_level_q;
  assign w_overflow    = w_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
//------------------------------------------------------------------------------
// tb_fifo_wr_ctrl : directed self-checking bench for fifo_wr_ctrl
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_ctrl;

  logic       w_clk;
  logic       w_rst;
  logic       w_inc;
  logic [3:0] wq2_rptr;
  logic       w_ovf_clr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_level;
  logic       w_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_ctrl #(.ADDR_W(3), .AF_THRESH(6)) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_inc        (w_inc),
    .wq2_rptr     (wq2_rptr),
    .w_ovf_clr    (w_ovf_clr),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .w_ptr        (w_ptr),
    .w_full       (w_full),
    .w_almost_full(w_almost_full),
    .w_level      (w_level),
    .w_overflow   (w_overflow)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(w_addr),        32'd0);
    check({tag, "_ptr"},   32'(w_ptr),         32'd0);
    check({tag, "_full"},  32'(w_full),        32'd0);
    check({tag, "_af"},    32'(w_almost_full), 32'd0);
    check({tag, "_level"}, 32'(w_level),       32'd0);
    check({tag, "_ovf"},   32'(w_overflow),    32'd0);
    check({tag, "_en"},    32'(w_en),          32'd0);
  endtask

  initial begin
    logic [3:0] bin;
    logic [3:0] prev;
    logic       seen_wrap;

    w_rst     = 1'b1;
    w_inc     = 1'b0;
    wq2_rptr  = 4'd0;
    w_ovf_clr = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    w_rst = 1'b0;

    // Fill from empty
    for (int i = 0; i < 8; i++) begin
      w_inc = 1'b1;
      #1;
      check("fill_en",   32'(w_en),   32'd1);
      check("fill_addr", 32'(w_addr), 32'(i));
      tick();
      check("fill_level", 32'(w_level), 32'(i + 1));
      check("fill_full",  32'(w_full),  32'(i == 7));
      check("fill_ptr",   32'(w_ptr),   32'(gray(4'(i + 1))));
    end
    check("full_ptr",  32'(w_ptr),  32'hC);
    check("full_addr", 32'(w_addr), 32'd0);
    check("full_af",   32'(w_almost_full), 32'd1);

    // Blocked write while full
    #1;
    check("blocked_en", 32'(w_en), 32'd0);
    tick();
    check("blocked_ovf",  32'(w_overflow), 32'd1);
    check("blocked_ptr",  32'(w_ptr),      32'hC);
    check("blocked_addr", 32'(w_addr),     32'd0);
    check("blocked_lvl",  32'(w_level),    32'd8);

    w_inc     = 1'b0;
    w_ovf_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(w_overflow), 32'd0);

    w_inc = 1'b1;
    tick();
    check("ovf_set_wins", 32'(w_overflow), 32'd1);
    check("ovf_set_ptr",  32'(w_ptr),      32'hC);

    // Read pointer advances by one
    w_inc     = 1'b0;
    w_ovf_clr = 1'b0;
    wq2_rptr  = 4'b0001;
    tick();
    check("rd_full",  32'(w_full),        32'd0);
    check("rd_level", 32'(w_level),       32'd7);
    check("rd_af",    32'(w_almost_full), 32'd1);
    check("rd_ovf",   32'(w_overflow),    32'd1);

    // Almost-full threshold
    w_rst = 1'b1;
    #1;
    w_rst    = 1'b0;
    wq2_rptr = 4'd0;
    for (int i = 0; i < 6; i++) begin
      w_inc = 1'b1;
      tick();
      check("af_level", 32'(w_level),       32'(i + 1));
      check("af_flag",  32'(w_almost_full), 32'(i >= 5));
    end
    w_inc = 1'b0;

    // Asynchronous reset mid-operation
    w_rst = 1'b1;
    #1;
    w_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_inc = 1'b1;
      tick();
    end
    w_inc = 1'b0;
    check("pre_rst_addr", 32'(w_addr),  32'd5);
    check("pre_rst_lvl",  32'(w_level), 32'd5);
    #1;
    w_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    w_rst = 1'b0;
    w_inc = 1'b1;
    #1;
    check("post_rst_addr", 32'(w_addr), 32'd0);
    check("post_rst_en",   32'(w_en),   32'd1);
    tick();
    check("post_rst_ptr",  32'(w_ptr),  32'd1);
    check("post_rst_addr1", 32'(w_addr), 32'd1);
    w_inc = 1'b0;

    // Wrap-around with the read pointer trailing by two
    w_rst = 1'b1;
    #1;
    w_rst    = 1'b0;
    wq2_rptr = 4'd0;
    w_inc    = 1'b1;
    repeat (2) tick();
    bin = 4'd2;
    check("wrap_start_lvl", 32'(w_level), 32'd2);
    prev      = w_ptr;
    seen_wrap = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wq2_rptr = gray(4'(bin - 4'd1));
      w_inc    = 1'b1;
      tick();
      bin = bin + 4'd1;
      check("wrap_ptr",    32'(w_ptr),                  32'(gray(bin)));
      check("wrap_onebit", 32'($countones(prev ^ w_ptr)), 32'd1);
      check("wrap_level",  32'(w_level),                32'd2);
      check("wrap_full",   32'(w_full),                 32'd0);
      if (prev == 4'b1000 && w_ptr == 4'b0000) begin
        seen_wrap = 1'b1;
      end
      prev = w_ptr;
    end
    w_inc = 1'b0;
    check("wrap_seen", 32'(seen_wrap), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
